spi_master_ctrl: RTL and testbench

- Host-side SPI master that sits directly upstream of the SPI slave / single-port RAM block. It drives SS_n and MOSI into the slave and samples MISO from it.
- Turns one host request (opcode + byte) into one complete SPI frame. For read-data frames it returns the captured byte to the host.
- The serial clock is the system clock; SS_n and MOSI change on the rising edge, and the slave samples them on the next rising edge.

---
 rtl/spi_master_pkg.sv | 30 +++
 rtl/spi_master_shifter.sv | 58 +++++
 rtl/spi_master_ctrl.sv | 134 +++++++++++++
 tb/tb_spi_master_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_pkg.sv
// Shared types and constants for the host-side SPI master.
package spi_master_pkg;

  localparam int PAYLOAD_W = 10;
  localparam int DATA_W    = 8;
  localparam int CNT_W     = 4;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEL,
    S_MODE,
    S_SHIFT,
    S_WAIT,
    S_CAPTURE,
    S_GAP
  } state_e;

  // A read-data frame carries a zero byte; the slave only needs the opcode.
  function automatic logic [PAYLOAD_W-1:0] build_payload(op_e op, logic [DATA_W-1:0] data);
    return {op, (op == RD_DATA) ? {DATA_W{1'b0}} : data};
  endfunction

endpackage

// File: rtl/spi_master_shifter.sv
// Datapath of the SPI master: PISO for the outgoing payload, SIPO for MISO,
// and the per-state cycle counter used by the controlling FSM.
module spi_master_shifter
  import spi_master_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [PAYLOAD_W-1:0] load_payload,
  input  logic                 shift_en,
  output logic                 tx_bit,
  input  logic                 cnt_clr,
  input  logic                 cnt_en,
  output logic [CNT_W-1:0]     cnt,
  input  logic                 rx_en,
  input  logic                 miso,
  output logic [DATA_W-1:0]    rx_next
);

  logic [PAYLOAD_W-1:0] tx_q;
  logic [DATA_W-1:0]    rx_q;
  logic [CNT_W-1:0]     cnt_q;

  assign tx_bit  = tx_q[0];
  assign cnt     = cnt_q;
  // LSB arrives first, so each new bit enters at the top and walks down.
  assign rx_next = {miso, rx_q[DATA_W-1:1]};

  // NOTE: sequential state uses <= so every register updates from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q <= '0;
    end else if (load) begin
      tx_q <= load_payload;
    end else if (shift_en) begin
      tx_q <= tx_q >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (cnt_en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q <= '0;
    end else if (rx_en) begin
      rx_q <= rx_next;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// Host-side SPI master: one host request becomes one SPI frame; read-data
// frames return the byte captured from MISO.
module spi_master_ctrl
  import spi_master_pkg::*;
#(
  parameter int RD_LAT = 2,
  parameter int GAP    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [DATA_W-1:0] req_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              SS_n,
  output logic              MOSI,
  input  logic              MISO
);

  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(PAYLOAD_W - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] CAP_LAST   = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP - 1);

  state_e             state_q, state_d;
  op_e                op_q;
  logic               hs;
  logic               tx_bit;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  rx_next;

  logic ss_n_d, mosi_d, ready_d, busy_d, rd_done;
  logic shift_en, cnt_clr, cnt_en, rx_en;

  assign hs = req_valid && req_ready;

  spi_master_shifter u_shifter (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (hs),
    .load_payload (build_payload(op_e'(req_op), req_data)),
    .shift_en     (shift_en),
    .tx_bit       (tx_bit),
    .cnt_clr      (cnt_clr),
    .cnt_en       (cnt_en),
    .cnt          (cnt),
    .rx_en        (rx_en),
    .miso         (MISO),
    .rx_next      (rx_next)
  );

  // State register together with the registered pin outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= WR_ADDR;
      SS_n      <= 1'b1;
      MOSI      <= 1'b0;
      req_ready <= 1'b0;
      busy      <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      state_q   <= state_d;
      SS_n      <= ss_n_d;
      MOSI      <= mosi_d;
      req_ready <= ready_d;
      busy      <= busy_d;
      rd_valid  <= rd_done;
      if (hs)      op_q    <= op_e'(req_op);
      if (rd_done) rd_data <= rx_next;
    end
  end

  // Next-state logic; cnt counts cycles spent in the current state from 0.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (hs) state_d = S_SEL;
      S_SEL:     state_d = S_MODE;
      S_MODE:    state_d = S_SHIFT;
      S_SHIFT: begin
        if (cnt == SHIFT_LAST) begin
          if (op_q != RD_DATA)  state_d = S_GAP;
          else if (RD_LAT == 0) state_d = S_CAPTURE;
          else                  state_d = S_WAIT;
        end
      end
      S_WAIT:    if (cnt == WAIT_LAST) state_d = S_CAPTURE;
      S_CAPTURE: if (cnt == CAP_LAST)  state_d = S_GAP;
      S_GAP:     if (cnt == GAP_LAST)  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from state_d and registered, so the pins line up
  // with state_q without an extra cycle of lag.
  // NOTE: every variable gets a default first so no latch is inferred.
  always_comb begin
    ss_n_d   = 1'b1;
    mosi_d   = 1'b0;
    ready_d  = 1'b0;
    busy_d   = 1'b1;
    shift_en = 1'b0;
    unique case (state_d)
      S_IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
      S_SEL:     ss_n_d = 1'b0;
      S_MODE: begin
        ss_n_d = 1'b0;
        mosi_d = op_q[1];
      end
      S_SHIFT: begin
        ss_n_d   = 1'b0;
        mosi_d   = tx_bit;
        shift_en = 1'b1;
      end
      S_WAIT:    ss_n_d = 1'b0;
      S_CAPTURE: ss_n_d = 1'b0;
      S_GAP:     ss_n_d = 1'b1;
      default:   ss_n_d = 1'b1;
    endcase
    cnt_clr = (state_d != state_q);
    cnt_en  = (state_q != S_IDLE);
    rx_en   = (state_q == S_CAPTURE);
    rd_done = (state_q == S_CAPTURE) && (cnt == CAP_LAST);
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl with a behavioural SPI slave/RAM model.
module tb_spi_master_ctrl;
  import spi_master_pkg::*;

  localparam int CAP0 = 12 + 2;  // first capture cycle index within SS_n-low time

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [1:0] req_op = 2'b00;
  logic [7:0] req_data = 8'h00;
  logic       MISO = 1'b1;
  logic       req_ready, rd_valid, busy, SS_n, MOSI;
  logic [7:0] rd_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Frame monitor state
  int          cur_low = 0, last_low = 0, frames = 0, gap_cnt = 0;
  int          busy_err = 0, rd_pulses = 0;
  logic [31:0] mosi_cur = '0, mosi_log = '0;

  // Slave model state
  int         m_idx = 0;
  logic       m_read = 1'b0;
  logic [9:0] m_pay = '0;
  logic [7:0] m_wa = '0, m_ra = '0;
  logic [7:0] m_mem [256];
  logic [7:0] exp_mem [256];

  spi_master_ctrl #(.RD_LAT(2), .GAP(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_data  (req_data),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .busy      (busy),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!SS_n) begin
      if (cur_low < 32) mosi_cur[cur_low] = MOSI;
      cur_low++;
      if (!busy) busy_err++;
    end else if (cur_low != 0) begin
      last_low = cur_low;
      mosi_log = mosi_cur;
      mosi_cur = '0;
      cur_low  = 0;
      gap_cnt  = 0;
      frames++;
    end
    if (SS_n && !req_ready && busy) gap_cnt++;
    if (rd_valid) rd_pulses++;
  end

  // Slave: decodes {op, byte} after the 12th low cycle; answers RD_DATA on MISO.
  always @(negedge clk) begin
    if (SS_n) begin
      m_idx  = 0;
      m_read = 1'b0;
      MISO   = 1'b1;
    end else begin
      if (m_idx >= 2 && m_idx <= 11) m_pay[m_idx-2] = MOSI;
      if (m_idx == 11) begin
        case (m_pay[9:8])
          2'b00:   m_wa = m_pay[7:0];
          2'b01:   m_mem[m_wa] = m_pay[7:0];
          2'b10:   m_ra = m_pay[7:0];
          default: m_read = 1'b1;
        endcase
      end
      if (m_read && m_idx >= CAP0 && m_idx < CAP0 + 8) MISO = m_mem[m_ra][m_idx-CAP0];
      else MISO = 1'b1;
      m_idx++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] d, input bit keep, output int t_acc);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_data  = d;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept", {31'd0, req_ready}, 32'd1);
    t_acc = cyc;
    @(posedge clk);
    if (!keep) begin
      #1;
      req_valid = 1'b0;
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    #1;
    check(tag, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    int t1, t2, f0, p0, n;
    logic [7:0] d;

    // Reset
    repeat (3) @(negedge clk);
    check("rst_ss_n",      {31'd0, SS_n},      32'd1);
    check("rst_mosi",      {31'd0, MOSI},      32'd0);
    check("rst_rd_valid",  {31'd0, rd_valid},  32'd0);
    check("rst_rd_data",   {24'd0, rd_data},   32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rel_req_ready", {31'd0, req_ready}, 32'd1);

    // WR_ADDR 0x5A: 12 low cycles, MOSI 0,0 then 0,1,0,1,1,0,1,0,0,0
    send(WR_ADDR, 8'h5A, 1'b0, t1);
    wait_ready("wr_addr_done");
    check("wr_addr_len",  last_low,       32'd12);
    check("wr_addr_mosi", mosi_log[11:0], 32'h168);
    check("wr_addr_gap",  gap_cnt,        32'd1);
    check("wr_addr_no_rv", rd_pulses,     32'd0);
    check("slave_wa",     {24'd0, m_wa},  32'h5A);

    // RD_DATA returning 0xC3 (stored at 0x5A); req_data ignored
    send(WR_DATA, 8'hC3, 1'b0, t1);
    wait_ready("wr_data_done");
    send(RD_ADDR, 8'h5A, 1'b0, t1);
    wait_ready("rd_addr_done");
    check("rd_addr_no_rv", rd_pulses, 32'd0);
    send(RD_DATA, 8'hFF, 1'b0, t1);
    wait_ready("rd_data_done");
    check("rd_len",    last_low,       32'd22);
    check("rd_mosi",   mosi_log[21:0], 32'h000C02);
    check("rd_pulses", rd_pulses,      32'd1);
    check("rd_c3",     {24'd0, rd_data}, 32'hC3);

    // Full loop 0x10 <- 0xA7
    send(WR_ADDR, 8'h10, 1'b0, t1); wait_ready("loop_wa");
    send(WR_DATA, 8'hA7, 1'b0, t1); wait_ready("loop_wd");
    send(RD_ADDR, 8'h10, 1'b0, t1); wait_ready("loop_ra");
    send(RD_DATA, 8'h00, 1'b0, t1); wait_ready("loop_rd");
    check("loop_a7",     {24'd0, rd_data}, 32'hA7);
    check("loop_pulses", rd_pulses,        32'd2);

    // Back-to-back with req_valid held high
    f0 = frames;
    send(WR_ADDR, 8'h21, 1'b1, t1);
    send(WR_DATA, 8'h9C, 1'b0, t2);
    wait_ready("b2b_done");
    check("b2b_spacing", t2 - t1,            32'd14);
    check("b2b_frames",  frames - f0,        32'd2);
    check("b2b_mem",     {24'd0, m_mem[8'h21]}, 32'h9C);
    check("b2b_busy",    busy_err,           32'd0);
    check("b2b_hold",    {24'd0, rd_data},   32'hA7);

    // Sweep all addresses
    for (int a = 0; a < 256; a++) begin
      d = 8'($urandom_range(0, 255));
      exp_mem[a] = d;
      send(WR_ADDR, 8'(a), 1'b0, t1); wait_ready("sw_wa");
      send(WR_DATA, d,     1'b0, t1); wait_ready("sw_wd");
    end
    p0 = rd_pulses;
    for (int a = 0; a < 256; a++) begin
      send(RD_ADDR, 8'(a), 1'b0, t1); wait_ready("sw_ra");
      send(RD_DATA, 8'h00, 1'b0, t1); wait_ready("sw_rd");
      check($sformatf("sweep_rd_%0d", a), {24'd0, rd_data}, {24'd0, exp_mem[a]});
    end
    check("sweep_pulses", rd_pulses - p0, 32'd256);

    // Reset during CAPTURE bit 4
    send(RD_ADDR, 8'h10, 1'b0, t1); wait_ready("mr_ra");
    p0 = rd_pulses;
    send(RD_DATA, 8'h00, 1'b0, t1);
    n = 0;
    while (cur_low != CAP0 + 4 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("mr_reach_cap4", cur_low, CAP0 + 4);
    #2 rst_n = 1'b0;
    #1;
    check("mr_ss_n",    {31'd0, SS_n},    32'd1);
    check("mr_busy",    {31'd0, busy},    32'd0);
    check("mr_rd_data", {24'd0, rd_data}, 32'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_ready("mr_release");
    check("mr_no_pulse", rd_pulses - p0,   32'd0);
    check("mr_rd_hold",  {24'd0, rd_data}, 32'h00);
    send(RD_DATA, 8'h00, 1'b0, t1);
    wait_ready("mr_rd_done");
    check("mr_rd_len",   last_low,         32'd22);
    check("mr_rd_data2", {24'd0, rd_data}, {24'd0, exp_mem[8'h10]});
    check("mr_pulse",    rd_pulses - p0,   32'd1);
    check("busy_frames", busy_err,         32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
